dport_arb: RTL and testbench

DPORT_ARB -- requirements
Module: dport_arb

---
 rtl/dport_arb_pkg.sv | 21 ++
 rtl/dport_arb_fifo.sv | 63 ++++++
 rtl/dport_arb.sv | 157 +++++++++++++++
 tb/tb_dport_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dport_arb_pkg.sv
// Shared types for the dual-port arbiter: owner ID, request bundle and tag width.
package dport_arb_pkg;

    localparam int DPORT_TAG_W = 11;

    typedef logic [0:0] owner_t;

    typedef struct packed {
        logic [31:0]            addr;
        logic [31:0]            data_wr;
        logic                   rd;
        logic [3:0]             wr;
        logic [DPORT_TAG_W-1:0] tag;
    } req_t;

    // A requester is active on a read or any byte-write strobe.
    function automatic logic req_active(input req_t r);
        return r.rd | (r.wr != 4'b0000);
    endfunction

endpackage

// File: rtl/dport_arb_fifo.sv
// In-order owner FIFO: records which requester owns each outstanding downstream request.
module dport_arb_fifo
    import dport_arb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  owner_t din_i,
    output owner_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam logic [DEPTH_W:0]   FULL_CNT = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

    owner_t             mem_r [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_r;
    logic [DEPTH_W-1:0] rd_ptr_r;
    logic [DEPTH_W:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Status and qualified push/pop; push is refused when full even if a pop happens too.
    always_comb begin
        full_o    = (count_r == FULL_CNT);
        empty_o   = (count_r == {(DEPTH_W+1){1'b0}});
        head_o    = mem_r[rd_ptr_r];
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
    end

    // Pointer, count and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {DEPTH_W{1'b0}};
            rd_ptr_r <= {DEPTH_W{1'b0}};
            count_r  <= {(DEPTH_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 1'b0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din_i;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dport_arb.sv
// Two-requester memory port arbiter with in-order response routing.
// Define DPORT_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0).
module dport_arb
    import dport_arb_pkg::*;
#(
    parameter int OUTSTANDING   = 4,
    parameter int OUTSTANDING_W = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            mem0_addr_i,
    input  logic [31:0]            mem0_data_wr_i,
    input  logic                   mem0_rd_i,
    input  logic [3:0]             mem0_wr_i,
    input  logic [DPORT_TAG_W-1:0] mem0_req_tag_i,
    output logic                   mem0_accept_o,
    output logic                   mem0_ack_o,
    output logic                   mem0_error_o,
    output logic [31:0]            mem0_data_rd_o,
    output logic [DPORT_TAG_W-1:0] mem0_resp_tag_o,
    input  logic [31:0]            mem1_addr_i,
    input  logic [31:0]            mem1_data_wr_i,
    input  logic                   mem1_rd_i,
    input  logic [3:0]             mem1_wr_i,
    input  logic [DPORT_TAG_W-1:0] mem1_req_tag_i,
    output logic                   mem1_accept_o,
    output logic                   mem1_ack_o,
    output logic                   mem1_error_o,
    output logic [31:0]            mem1_data_rd_o,
    output logic [DPORT_TAG_W-1:0] mem1_resp_tag_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_data_wr_o,
    output logic                   mem_rd_o,
    output logic [3:0]             mem_wr_o,
    output logic [DPORT_TAG_W-1:0] mem_req_tag_o,
    input  logic                   mem_accept_i,
    input  logic                   mem_ack_i,
    input  logic                   mem_error_i,
    input  logic [31:0]            mem_data_rd_i,
    input  logic [DPORT_TAG_W-1:0] mem_resp_tag_i,
    output logic                   protocol_err_o
);

    req_t   req0_s, req1_s, sel_req_s;
    logic   act0_s, act1_s;
    owner_t grant_s;
    owner_t hold_owner_r;
    owner_t head_s;
    logic   hold_r;
    logic   full_s, empty_s;
    logic   present_s, accept_s, pop_s;
    logic   perr_r;
`ifdef DPORT_ARB_RR_EN
    owner_t last_r;
`endif

    // Bundle requester inputs and decode activity.
    always_comb begin
        req0_s = '{addr: mem0_addr_i, data_wr: mem0_data_wr_i, rd: mem0_rd_i,
                   wr: mem0_wr_i, tag: mem0_req_tag_i};
        req1_s = '{addr: mem1_addr_i, data_wr: mem1_data_wr_i, rd: mem1_rd_i,
                   wr: mem1_wr_i, tag: mem1_req_tag_i};
        act0_s = req_active(req0_s);
        act1_s = req_active(req1_s);
    end

    // Grant selection: a stalled request keeps the grant until it is accepted.
    always_comb begin
        grant_s = 1'b0;
        if (hold_r) begin
            grant_s = hold_owner_r;
        end else if (act0_s && act1_s) begin
`ifdef DPORT_ARB_RR_EN
            grant_s = (last_r == 1'b0) ? 1'b1 : 1'b0;
`else
            grant_s = 1'b0;
`endif
        end else if (act1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Combinational request path to downstream, suppressed while the owner FIFO is full.
    always_comb begin
        sel_req_s     = (grant_s == 1'b1) ? req1_s : req0_s;
        present_s     = ((grant_s == 1'b1) ? act1_s : act0_s) & ~full_s;
        accept_s      = mem_accept_i & present_s;
        mem_addr_o    = sel_req_s.addr;
        mem_data_wr_o = sel_req_s.data_wr;
        mem_req_tag_o = sel_req_s.tag;
        mem_rd_o      = sel_req_s.rd & ~full_s;
        mem_wr_o      = full_s ? 4'b0000 : sel_req_s.wr;
        mem0_accept_o = accept_s & (grant_s == 1'b0);
        mem1_accept_o = accept_s & (grant_s == 1'b1);
    end

    // Response routing to the FIFO head owner; the other requester sees nothing.
    always_comb begin
        pop_s           = mem_ack_i & ~empty_s;
        mem0_ack_o      = pop_s & (head_s == 1'b0);
        mem1_ack_o      = pop_s & (head_s == 1'b1);
        mem0_error_o    = mem0_ack_o & mem_error_i;
        mem1_error_o    = mem1_ack_o & mem_error_i;
        mem0_data_rd_o  = mem0_ack_o ? mem_data_rd_i  : 32'h0000_0000;
        mem1_data_rd_o  = mem1_ack_o ? mem_data_rd_i  : 32'h0000_0000;
        mem0_resp_tag_o = mem0_ack_o ? mem_resp_tag_i : {DPORT_TAG_W{1'b0}};
        mem1_resp_tag_o = mem1_ack_o ? mem_resp_tag_i : {DPORT_TAG_W{1'b0}};
        protocol_err_o  = perr_r;
    end

    // Grant hold tracking and sticky protocol error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_r       <= 1'b0;
            hold_owner_r <= 1'b0;
            perr_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                hold_r <= 1'b0;
            end else if (present_s) begin
                hold_r       <= 1'b1;
                hold_owner_r <= grant_s;
            end
            if (mem_ack_i && empty_s) begin
                perr_r <= 1'b1;
            end
        end
    end

`ifdef DPORT_ARB_RR_EN
    // Last-accepted requester for round-robin fairness.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_r <= 1'b1;
        end else if (accept_s) begin
            last_r <= grant_s;
        end
    end
`endif

    dport_arb_fifo #(
        .DEPTH   (OUTSTANDING),
        .DEPTH_W (OUTSTANDING_W)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept_s),
        .pop_i   (pop_s),
        .din_i   (grant_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

endmodule

// File: tb/tb_dport_arb.sv
// Scoreboard bench for dport_arb: expected grants/acks are queued by the stimulus, popped by a monitor.
module tb_dport_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] mem0_addr_i, mem0_data_wr_i, mem1_addr_i, mem1_data_wr_i;
    logic        mem0_rd_i, mem1_rd_i;
    logic [3:0]  mem0_wr_i, mem1_wr_i;
    logic [10:0] mem0_req_tag_i, mem1_req_tag_i;
    logic        mem0_accept_o, mem0_ack_o, mem0_error_o;
    logic        mem1_accept_o, mem1_ack_o, mem1_error_o;
    logic [31:0] mem0_data_rd_o, mem1_data_rd_o;
    logic [10:0] mem0_resp_tag_o, mem1_resp_tag_o;
    logic [31:0] mem_addr_o, mem_data_wr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic [10:0] mem_req_tag_o;
    logic        mem_accept_i, mem_ack_i, mem_error_i;
    logic [31:0] mem_data_rd_i;
    logic [10:0] mem_resp_tag_i;
    logic        protocol_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct { logic owner; logic [31:0] addr; } gexp_t;
    typedef struct { logic owner; logic err; logic [10:0] tag; logic [31:0] data; } aexp_t;
    gexp_t gq[$];
    aexp_t aq[$];

    always #5 clk = ~clk;

    dport_arb dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem0_addr_i(mem0_addr_i), .mem0_data_wr_i(mem0_data_wr_i), .mem0_rd_i(mem0_rd_i),
        .mem0_wr_i(mem0_wr_i), .mem0_req_tag_i(mem0_req_tag_i), .mem0_accept_o(mem0_accept_o),
        .mem0_ack_o(mem0_ack_o), .mem0_error_o(mem0_error_o), .mem0_data_rd_o(mem0_data_rd_o),
        .mem0_resp_tag_o(mem0_resp_tag_o),
        .mem1_addr_i(mem1_addr_i), .mem1_data_wr_i(mem1_data_wr_i), .mem1_rd_i(mem1_rd_i),
        .mem1_wr_i(mem1_wr_i), .mem1_req_tag_i(mem1_req_tag_i), .mem1_accept_o(mem1_accept_o),
        .mem1_ack_o(mem1_ack_o), .mem1_error_o(mem1_error_o), .mem1_data_rd_o(mem1_data_rd_o),
        .mem1_resp_tag_o(mem1_resp_tag_o),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_req_tag_o(mem_req_tag_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
        .mem_data_rd_i(mem_data_rd_i), .mem_resp_tag_i(mem_resp_tag_i),
        .protocol_err_o(protocol_err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented accept/ack against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (mem0_accept_o || mem1_accept_o) begin
                if (gq.size() == 0) begin
                    chk("unexpected_accept", {30'd0, mem1_accept_o, mem0_accept_o}, 32'd0);
                end else begin
                    gexp_t g;
                    g = gq.pop_front();
                    chk("grant_owner0", {31'd0, mem0_accept_o}, {31'd0, ~g.owner});
                    chk("grant_owner1", {31'd0, mem1_accept_o}, {31'd0, g.owner});
                    chk("grant_addr", mem_addr_o, g.addr);
                end
            end
            if (mem0_ack_o || mem1_ack_o) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", {30'd0, mem1_ack_o, mem0_ack_o}, 32'd0);
                end else begin
                    aexp_t a;
                    a = aq.pop_front();
                    chk("ack0", {31'd0, mem0_ack_o}, {31'd0, ~a.owner});
                    chk("ack1", {31'd0, mem1_ack_o}, {31'd0, a.owner});
                    chk("err0", {31'd0, mem0_error_o}, {31'd0, ~a.owner & a.err});
                    chk("err1", {31'd0, mem1_error_o}, {31'd0, a.owner & a.err});
                    chk("ack_tag", {21'd0, a.owner ? mem1_resp_tag_o : mem0_resp_tag_o}, {21'd0, a.tag});
                    chk("ack_data", a.owner ? mem1_data_rd_o : mem0_data_rd_o, a.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem0_addr_i = 32'h0; mem0_data_wr_i = 32'h0; mem0_rd_i = 1'b0; mem0_wr_i = 4'h0; mem0_req_tag_i = 11'h0;
        mem1_addr_i = 32'h0; mem1_data_wr_i = 32'h0; mem1_rd_i = 1'b0; mem1_wr_i = 4'h0; mem1_req_tag_i = 11'h0;
        mem_accept_i = 1'b1; mem_ack_i = 1'b0; mem_error_i = 1'b0;
        mem_data_rd_i = 32'h0; mem_resp_tag_i = 11'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic send_ack(input logic owner, input logic err, input logic [10:0] tag, input logic [31:0] data);
        mem_ack_i = 1'b1; mem_error_i = err; mem_resp_tag_i = tag; mem_data_rd_i = data;
        aq.push_back('{owner, err, tag, data});
        step();
        mem_ack_i = 1'b0; mem_error_i = 1'b0;
    endtask

    logic exp_own;

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        step();
        // Reset state
        chk("rst_perr", {31'd0, protocol_err_o}, 32'd0);
        chk("rst_acks", {28'd0, mem0_ack_o, mem1_ack_o, mem0_error_o, mem1_error_o}, 32'd0);
        chk("rst_accepts", {30'd0, mem0_accept_o, mem1_accept_o}, 32'd0);
        rst_i = 1'b0;
        step();

        // Single read from requester 0 then its ack
        mem0_rd_i = 1'b1; mem0_addr_i = 32'h100;
        gq.push_back('{1'b0, 32'h100});
        step();
        mem0_rd_i = 1'b0;
        send_ack(1'b0, 1'b0, 11'h005, 32'hDEAD_0100);

        // Contention for three cycles
        do_reset();
        mem0_rd_i = 1'b1; mem0_addr_i = 32'h200;
        mem1_rd_i = 1'b1; mem1_addr_i = 32'h300;
        for (int i = 0; i < 3; i++) begin
`ifdef DPORT_ARB_RR_EN
            exp_own = (i == 1);
`else
            exp_own = 1'b0;
`endif
            gq.push_back('{exp_own, exp_own ? 32'h300 : 32'h200});
            step();
        end
        idle_inputs();

        // Reset discards ownership; a later ack is a protocol error, cleared by reset
        do_reset();
        mem_ack_i = 1'b1; mem_resp_tag_i = 11'h3;
        step();
        mem_ack_i = 1'b0;
        chk("perr_set", {31'd0, protocol_err_o}, 32'd1);
        step();
        chk("perr_sticky", {31'd0, protocol_err_o}, 32'd1);
        do_reset();
        chk("perr_cleared", {31'd0, protocol_err_o}, 32'd0);

        // Grant hold while requester 1 is stalled
        mem_accept_i = 1'b0;
        mem1_rd_i = 1'b1; mem1_addr_i = 32'h400;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("stall_addr", mem_addr_o, 32'h400);
            chk("stall_accept", {30'd0, mem0_accept_o, mem1_accept_o}, 32'd0);
            step();
        end
        mem0_rd_i = 1'b1; mem0_addr_i = 32'h500;
        #2;
        chk("hold_addr", mem_addr_o, 32'h400);
        step();
        mem_accept_i = 1'b1;
        gq.push_back('{1'b1, 32'h400});
        step();
        mem1_rd_i = 1'b0;
        gq.push_back('{1'b0, 32'h500});
        step();
        idle_inputs();

        // Fill the owner FIFO, block the fifth request, release it with one ack
        do_reset();
        mem0_rd_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem0_addr_i = 32'h1000 + 32'(4 * i);
            gq.push_back('{1'b0, mem0_addr_i});
            step();
        end
        mem0_addr_i = 32'h1010;
        #2;
        chk("full_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("full_accept", {31'd0, mem0_accept_o}, 32'd0);
        step();
        mem_ack_i = 1'b1; mem_resp_tag_i = 11'h001; mem_data_rd_i = 32'h11;
        aq.push_back('{1'b0, 1'b0, 11'h001, 32'h11});
        #2;
        chk("full_pop_accept", {31'd0, mem0_accept_o}, 32'd0);
        step();
        mem_ack_i = 1'b0;
        gq.push_back('{1'b0, 32'h1010});
        step();
        mem0_rd_i = 1'b0;
        for (int i = 2; i < 6; i++) begin
            send_ack(1'b0, 1'b0, 11'(i), 32'(i * 16));
        end

        // Interleaved owners 0,1,1 with error on the second response
        do_reset();
        mem0_rd_i = 1'b1; mem0_addr_i = 32'hA0;
        gq.push_back('{1'b0, 32'hA0});
        step();
        mem0_rd_i = 1'b0;
        mem1_wr_i = 4'hF; mem1_addr_i = 32'hB0; mem1_data_wr_i = 32'h1234;
        gq.push_back('{1'b1, 32'hB0});
        step();
        mem1_addr_i = 32'hB4;
        gq.push_back('{1'b1, 32'hB4});
        step();
        mem1_wr_i = 4'h0;
        send_ack(1'b0, 1'b0, 11'h007, 32'h70);
        send_ack(1'b1, 1'b1, 11'h009, 32'h90);
        send_ack(1'b1, 1'b0, 11'h00A, 32'hA0);
        step();
        chk("no_perr_after_acks", {31'd0, protocol_err_o}, 32'd0);

        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("ack_queue_drained", 32'(aq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
